// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART programming-domain loader blocks.
//   loader_state_e : frame FSM states
//   LOADER_ADDR_W  : default word-address width of the target RAM
//   LEN_W          : width of the frame word-count field
//   tmo_cnt_w()    : counter width needed to hold a timeout cycle count
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_e;

  localparam int unsigned LOADER_ADDR_W = 14;
  localparam int unsigned LEN_W         = 16;

  function automatic int unsigned tmo_cnt_w(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte timeout down-counter.
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : reload with CYCLES (wins over en_i)
//   en_i         : count down one per cycle while high
//   expired_o    : high in the cycle that completes CYCLES enabled cycles
//                  since the last clear
// Reset value is 0; every path into an enabled state goes through a clear,
// so the zero value never produces a false expiry.
module loader_timeout
  import uart_loader_pkg::*;
#(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = tmo_cnt_w(CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = W'(CYCLES);
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // cnt_q==1 means this is the CYCLES-th idle cycle since the last byte.
  assign expired_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/uart_word_loader.sv
// UART image loader: turns a framed byte stream into RAM word writes.
// Frame: 16-bit LE word count N (1..2**ADDR_W), then 4*N data bytes, each
// word little-endian. Writes go out on upg_wen_o/upg_adr_o/upg_dat_o one
// cycle after the 4th byte of a word; upg_done_o is sticky once the whole
// image is written. Bad length or inter-byte timeout sets sticky err_o.
//   upg_clk_i, upg_rst_i   : clock, async active-high reset
//   rx_data_i, rx_valid_i  : byte stream from the UART receiver
//   upg_wen_o/adr_o/dat_o  : RAM write strobe, word address, word data
//   upg_done_o             : image loaded (sticky)
//   busy_o                 : frame in progress
//   err_o                  : malformed image (sticky)
// Optional macro LOADER_CHECKSUM_EN: a trailing byte equal to the XOR of
// all data bytes must follow the image before upg_done_o asserts.
module uart_word_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = LOADER_ADDR_W,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              busy_o,
  output logic              err_o
);

  // One extra bit so a full-depth image (N == DEPTH) can be counted.
  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  loader_state_e     state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [IDX_W-1:0]  n_q, n_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       sh_q, sh_d;      // lanes 0..2; lane 3 comes straight from rx
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  logic [LEN_W-1:0]  len_w;
  logic              len_ok;
  logic              last_word;
  logic              tmo_exp;

  assign busy_o = (state_q == LEN_HI) || (state_q == DATA) || (state_q == CHK);

  loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk_i     (upg_clk_i),
    .rst_i     (upg_rst_i),
    .clr_i     (rx_valid_i),
    .en_i      (busy_o),
    .expired_o (tmo_exp)
  );

  assign len_w     = {rx_data_i, len_lo_q};
  assign len_ok    = (len_w != '0) && (32'(len_w) <= DEPTH);
  assign last_word = (widx_q + IDX_W'(1)) == n_q;

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    n_d      = n_q;
    widx_d   = widx_q;
    bidx_d   = bidx_q;
    sh_d     = sh_q;
    wen_d    = 1'b0;
    adr_d    = adr_q;
    dat_d    = dat_q;
    // Flags follow the registered state, so they trail the state change by one cycle.
    done_d   = (state_q == DONE);
    err_d    = (state_q == ERR);
`ifdef LOADER_CHECKSUM_EN
    xor_d    = xor_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_valid_i) begin
          len_lo_d = rx_data_i;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (rx_valid_i) begin
          if (len_ok) begin
            n_d     = IDX_W'(len_w);
            widx_d  = '0;
            bidx_d  = '0;
            state_d = DATA;
          end else begin
            state_d = ERR;
          end
        end else if (tmo_exp) begin
          state_d = ERR;
        end
      end
      DATA: begin
        if (rx_valid_i) begin
          bidx_d = bidx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          xor_d  = xor_q ^ rx_data_i;
`endif
          case (bidx_q)
            2'd0:    sh_d[7:0]   = rx_data_i;
            2'd1:    sh_d[15:8]  = rx_data_i;
            2'd2:    sh_d[23:16] = rx_data_i;
            default: begin
              wen_d  = 1'b1;
              adr_d  = widx_q[ADDR_W-1:0];
              dat_d  = {rx_data_i, sh_q};
              widx_d = widx_q + IDX_W'(1);
              // Leave DATA now so a byte arriving during the write pulse
              // is never taken as image data.
              if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                state_d = CHK;
`else
                state_d = DONE;
`endif
              end
            end
          endcase
        end else if (tmo_exp) begin
          state_d = ERR;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (rx_valid_i) begin
          if (rx_data_i == xor_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
          end
        end else if (tmo_exp) begin
          state_d = ERR;
        end
      end
`endif
      DONE, ERR: ;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) begin
      state_q  <= IDLE;
      len_lo_q <= '0;
      n_q      <= '0;
      widx_q   <= '0;
      bidx_q   <= '0;
      sh_q     <= '0;
      wen_q    <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      n_q      <= n_d;
      widx_q   <= widx_d;
      bidx_q   <= bidx_d;
      sh_q     <= sh_d;
      wen_q    <= wen_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) xor_q <= '0;
    else           xor_q <= xor_d;
  end
`endif

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign err_o      = err_q;

endmodule

// File: doc/uart_word_loader.md
Name: uart_word_loader

Overview:
- Sits directly upstream of the data/instruction RAM programming port, in the UART programming clock domain.
- Consumes the byte stream from the UART receiver and assembles little-endian 32-bit words.
- Drives the upg_wen/upg_adr/upg_dat write strobe and raises upg_done once the whole image is written, which hands the RAM back to the CPU.
- Also catches malformed images (bad length, inter-byte timeout) and holds a sticky error flag.

Parameters:
ADDR_W, 14, word-address width; RAM depth DEPTH = 2**ADDR_W words.
TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes once a frame has started (100 ms at 10 MHz).

Ports:
upg_clk_i  input  1  UART programming clock; all logic on rising edge.
upg_rst_i  input  1  asynchronous, active-high reset.
rx_data_i  input  8  received byte.
rx_valid_i  input  1  one-cycle strobe; rx_data_i is valid in that cycle; may be high on consecutive cycles.
upg_wen_o  output  1  one-cycle RAM write pulse.
upg_adr_o  output  ADDR_W  word address for the write.
upg_dat_o  output  32  word data for the write.
upg_done_o  output  1  image fully loaded; sticky until reset.
busy_o  output  1  frame in progress (state LEN_HI, DATA or CHK).
err_o  output  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0; state IDLE; word count, byte index, word index, timeout counter and shift register all 0.
- Frame format:
  - 2-byte word count N, little-endian.
  - Then 4*N data bytes, each word little-endian (first byte is bits 7:0).
  - Legal N is 1..DEPTH.
- States and transitions:
  - IDLE: on rx_valid, latch the byte as N[7:0], go to LEN_HI.
  - LEN_HI: on rx_valid, form N. If N==0 or N>DEPTH, go to ERR; else go to DATA with word index 0 and byte index 0.
  - DATA: each rx_valid shifts the byte into lane [byte index] and increments the 2-bit byte index, which wraps.
    - When the 4th byte arrives in cycle t, upg_wen_o=1 in cycle t+1, with upg_adr_o = word index and upg_dat_o = assembled word.
    - upg_adr_o and upg_dat_o hold their values until the next write.
    - The word index increments after each write.
    - After write number N, go to DONE; upg_done_o=1 from cycle t+2 onward.
  - DONE: upg_done_o=1; all further bytes are ignored; no further write pulses.
  - ERR: err_o=1; upg_done_o stays 0; bytes are ignored; exit only via reset.
- Timeout:
  - The counter runs only in LEN_HI, DATA and CHK, and clears on every rx_valid.
  - When it reaches TIMEOUT_CYCLES, go to ERR.
  - If rx_valid arrives in the same cycle the count is reached, the byte wins and the counter clears.
- Back-to-back bytes at one per cycle: no byte is ever dropped; a write pulse overlaps with reception of the next word's first byte.
- Word index width is ADDR_W+1, so N==DEPTH terminates correctly; upg_adr_o carries only the low ADDR_W bits.
- Reset asserted mid-frame: immediate return to IDLE; all outputs 0 asynchronously; a partially written image is not signalled as done.

Optional Feature:
LOADER_CHECKSUM_EN
- With the macro defined:
  - After the last data byte the FSM enters CHK instead of DONE; the last word's write pulse still occurs.
  - The next byte is compared with the XOR of all 4*N data bytes.
  - Match: upg_done_o=1 from the following cycle. Mismatch: go to ERR, err_o=1.
  - The length bytes are excluded from the XOR.
- Without the macro: no CHK state and no XOR register; behaviour is exactly as above.

Decomposition:
- Shared package uart_loader_pkg holds:
  - state enum: IDLE, LEN_HI, DATA, CHK, DONE, ERR;
  - default ADDR_W;
  - the frame length-field width (16);
  - a function computing the timeout counter width from TIMEOUT_CYCLES.
- One sub-module is natural: loader_timeout.
  - Parameterised down-counter with clear, enable and an expired output.
  - Reused later by other UART-domain blocks.

Test Plan:
- Length 0x0002, then bytes 78 56 34 12 EF BE AD DE -> wen pulses at adr 0 dat 0x12345678 and adr 1 dat 0xDEADBEEF; done one cycle after the second pulse; err_o=0.
- Length 0x0000 -> err_o=1 two cycles after the second length byte; no wen; done stays 0. Repeat with 0x4001 (DEPTH+1) -> same result.
- N=0x4000 with bytes at one per cycle -> 16384 pulses, last at adr 0x3FFF; done asserted; no dropped byte (scoreboard compares every word).
- Stop after 5 data bytes; idle TIMEOUT_CYCLES (set to 50 in the bench) -> err_o=1 at cycle 50; no second wen. Also: a byte arriving exactly at cycle 50 -> no error.
- Assert upg_rst_i after the first write of a 3-word frame -> outputs 0 immediately; a fresh 1-word frame then loads at adr 0 and done asserts.
- LOADER_CHECKSUM_EN: frame N=1, data 01 02 04 08, checksum 0x0F -> done. Same frame with checksum 0x0E -> err_o=1; done stays 0.
